// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit near its centre and
// presents good bytes with a one-cycle valid strobe; bad stop bits raise a framing strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreakWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_sync_q;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreakWait;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreakWait: begin
        // Hold here through a break so a low line cannot spawn repeated frames.
        cnt_d = '0;
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Active    = (state_q != StIdle) && (state_q != StBreakWait);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, back-to-back, glitch, break, reset and baud skew.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic       dv, fe, act, dv2, fe2, act2;
  logic [7:0] rx_byte, byte2;

  int n_vec = 0;
  int n_fail = 0;

  int dv_hi, dv_rise, fe_hi, fe_rise, act_cyc, both, cyc, fe2_hi;
  logic dv_prev = 1'b0, fe_prev = 1'b0, dv2_prev = 1'b0;
  logic [7:0] got_bytes[$];
  int         dv_cyc[$];
  logic [7:0] got2[$];

  always #50 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_RX_Serial   (rx),
    .o_RX_DV       (dv),
    .o_RX_Byte     (rx_byte),
    .o_RX_Active   (act),
    .o_RX_Frame_Err(fe)
  );

  // At 8 clocks/bit the synchronizer lag leaves too little margin for a fast sender,
  // so the fast-skew case uses a 16 clocks/bit instance.
  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_RX_Serial   (rx2),
    .o_RX_DV       (dv2),
    .o_RX_Byte     (byte2),
    .o_RX_Active   (act2),
    .o_RX_Frame_Err(fe2)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dv) begin
      dv_hi = dv_hi + 1;
      if (!dv_prev) begin
        dv_rise = dv_rise + 1;
        got_bytes.push_back(rx_byte);
        dv_cyc.push_back(cyc);
      end
    end
    if (fe) begin
      fe_hi = fe_hi + 1;
      if (!fe_prev) fe_rise = fe_rise + 1;
    end
    if (act) act_cyc = act_cyc + 1;
    if (dv && fe) both = both + 1;
    dv_prev = dv;
    fe_prev = fe;
    if (dv2 && !dv2_prev) got2.push_back(byte2);
    if (fe2) fe2_hi = fe2_hi + 1;
    dv2_prev = dv2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dv_hi = 0; dv_rise = 0; fe_hi = 0; fe_rise = 0; act_cyc = 0; both = 0; fe2_hi = 0;
    got_bytes.delete();
    dv_cyc.delete();
    got2.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; per is the bit period in time units (100 per clock).
  task automatic send(input logic [7:0] b, input logic stop, input int per, input bit ch);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (ch) rx2 = fr[i];
      else rx = fr[i];
      #(per);
    end
    if (ch) rx2 = 1'b1;
    else rx = 1'b1;
  endtask

  logic [7:0] c3;

  initial begin
    cyc = 0;
    clr();
    // Reset values
    idle(3);
    check("rst_dv", dv, 0);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_active", act, 0);
    check("rst_ferr", fe, 0);
    rst_n = 1'b1;
    idle(20);

    // Single frame 0xA5
    @(posedge clk); clr(); @(negedge clk);
    send(8'hA5, 1'b1, 800, 1'b0);
    idle(16);
    check("a5_dv_pulses", dv_rise, 1);
    check("a5_dv_cycles", dv_hi, 1);
    check("a5_byte", got_bytes[0], 8'hA5);
    check("a5_ferr", fe_hi, 0);
    check("a5_active_cycles", act_cyc, 76);

    // Back-to-back 0x00, 0xFF with no idle gap
    @(posedge clk); clr(); @(negedge clk);
    send(8'h00, 1'b1, 800, 1'b0);
    send(8'hFF, 1'b1, 800, 1'b0);
    idle(16);
    check("b2b_dv_pulses", dv_rise, 2);
    check("b2b_byte0", got_bytes[0], 8'h00);
    check("b2b_byte1", got_bytes[1], 8'hFF);
    check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 80);

    // Two-clock glitch then a good 0x5A
    @(posedge clk); clr(); @(negedge clk);
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    check("glitch_active_cycles", act_cyc, 4);
    check("glitch_dv", dv_rise, 0);
    check("glitch_ferr", fe_hi, 0);
    check("glitch_idle", act, 0);
    @(posedge clk); clr(); @(negedge clk);
    send(8'h5A, 1'b1, 800, 1'b0);
    idle(16);
    check("5a_dv_pulses", dv_rise, 1);
    check("5a_byte", got_bytes[0], 8'h5A);

    // Framing error with a held break after a good 0xA5
    send(8'hA5, 1'b1, 800, 1'b0);
    idle(16);
    @(posedge clk); clr(); @(negedge clk);
    send(8'h3C, 1'b0, 800, 1'b0);
    rx = 1'b0;
    #(8000);
    check("brk_active", act, 0);
    #(8000);
    rx = 1'b1;
    idle(16);
    check("fe_pulses", fe_rise, 1);
    check("fe_cycles", fe_hi, 1);
    check("fe_no_dv", dv_rise, 0);
    check("fe_byte_kept", rx_byte, 8'hA5);
    check("fe_dv_overlap", both, 0);
    @(posedge clk); clr(); @(negedge clk);
    send(8'h81, 1'b1, 800, 1'b0);
    idle(16);
    check("post_fe_dv", dv_rise, 1);
    check("post_fe_byte", got_bytes[0], 8'h81);

    // Reset asserted off-edge during data bit 4 of 0xC3
    @(posedge clk); clr(); @(negedge clk);
    c3 = 8'hC3;
    rx = 1'b0;
    #(800);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      #(800);
    end
    rx = c3[4];
    #(420);
    rst_n = 1'b0;
    #1;
    check("mid_rst_active", act, 0);
    check("mid_rst_dv", dv, 0);
    check("mid_rst_byte", rx_byte, 8'h00);
    check("mid_rst_ferr", fe, 0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(16);
    check("mid_rst_no_strobe", dv_rise + fe_rise, 0);
    @(posedge clk); clr(); @(negedge clk);
    send(8'h81, 1'b1, 800, 1'b0);
    idle(16);
    check("post_rst_dv", dv_rise, 1);
    check("post_rst_byte", got_bytes[0], 8'h81);

    // Slow sender (+3%) at 8 clocks/bit
    @(posedge clk); clr(); @(negedge clk);
    send(8'h55, 1'b1, 824, 1'b0); #(800);
    send(8'hAA, 1'b1, 824, 1'b0); #(800);
    send(8'h01, 1'b1, 824, 1'b0); #(800);
    idle(8);
    check("slow_dv_pulses", dv_rise, 3);
    check("slow_byte0", got_bytes[0], 8'h55);
    check("slow_byte1", got_bytes[1], 8'hAA);
    check("slow_byte2", got_bytes[2], 8'h01);
    check("slow_ferr", fe_hi, 0);

    // Fast sender (-3%) at 16 clocks/bit
    @(posedge clk); clr(); @(negedge clk);
    send(8'h55, 1'b1, 1552, 1'b1); #(1600);
    send(8'hAA, 1'b1, 1552, 1'b1); #(1600);
    send(8'h01, 1'b1, 1552, 1'b1); #(1600);
    idle(8);
    check("fast_dv_pulses", got2.size(), 3);
    check("fast_byte0", got2[0], 8'h55);
    check("fast_byte1", got2[1], 8'hAA);
    check("fast_byte2", got2[2], 8'h01);
    check("fast_ferr", fe2_hi, 0);
    check("fast_idle", act2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
